// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main control FSM of the multi-cycle RV32 core. Sequences each
//             instruction through FETCH / DECODE / EXEC / MEM / WB and drives
//             the datapath enables, ALU operand selects and 2-bit ALUOp.
//             The memory request is held until mem_ready completes it.
//  Ports    : clk, rst (sync, active-high), en (run enable, sampled at
//             instruction boundaries), opcode (instr[6:0] from IR),
//             mem_ready (memory completes the request this cycle)
//             -> mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
//                pc_src, alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_write,
//                mem_to_reg, instr_done, illegal
//  Options  : `define PERF_COUNTERS_EN adds cycle_cnt / instret_cnt
//             (CNT_W bits wide, wrapping).
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [6:0] C_OP_R    = 7'b0110011;
  localparam logic [6:0] C_OP_ADDI = 7'b0010011;
  localparam logic [6:0] C_OP_LW   = 7'b0000011;
  localparam logic [6:0] C_OP_SW   = 7'b0100011;
  localparam logic [6:0] C_OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t     r_state;
  logic [6:0] r_op;        // opcode captured in DECODE, valid until instr_done
  logic       w_known;
  state_t     w_boundary;  // where to go once the current instruction retires

  always_comb begin
    w_known = (opcode == C_OP_R)  || (opcode == C_OP_ADDI) ||
              (opcode == C_OP_LW) || (opcode == C_OP_SW)   ||
              (opcode == C_OP_BEQ);
    w_boundary = en ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (en) r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_op    <= opcode;
          r_state <= w_known ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (r_op)
            C_OP_R, C_OP_ADDI: r_state <= S_WB;
            C_OP_LW, C_OP_SW:  r_state <= S_MEM;
            C_OP_BEQ:          r_state <= w_boundary;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (mem_ready) r_state <= (r_op == C_OP_LW) ? S_WB : w_boundary;
        end
        S_WB:     r_state <= w_boundary;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. The fetch/store completion
  // strobes must react to mem_ready in the same cycle, so they cannot be
  // registered a cycle ahead without adding a wait state to every access.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;          // PC + 4
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;          // PC + imm: speculative branch target
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (r_op)
          C_OP_R: begin
            alu_src_b = 2'b00;
            alu_op    = 2'b10;
          end
          C_OP_BEQ: begin
            alu_src_b     = 2'b00;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            instr_done    = 1'b1;
          end
          default: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b00;
          end
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_we     = (r_op == C_OP_SW);
        instr_done = (r_op == C_OP_SW) && mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_op == C_OP_LW);
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Scoreboard bench for multicycle_control. Instructions (opcode
//             plus fetch/memory wait counts) are queued for a memory responder;
//             a reference model pushes the expected per-instruction behaviour
//             and a monitor compares on every instr_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic clk, rst, en, mem_ready;
  logic [6:0] opcode;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic alu_src_a, reg_write, mem_to_reg, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op;
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif
  logic [14:0] outs;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
`ifdef PERF_COUNTERS_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .illegal(illegal)
  );

  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [6:0] op; int fw; int mw; } stim_t;
  typedef struct { int lat; int rw; int m2r; int we; int io; int pwc; int a10; int a01; } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int total_lat  = 0;
  int total_done = 0;
  bit in_i = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: what the instruction should look like end to end.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit lw, sw, r, addi, beq;
    lw = (s.op == OP_LW); sw = (s.op == OP_SW); r = (s.op == OP_R);
    addi = (s.op == OP_ADDI); beq = (s.op == OP_BEQ);
    e.lat = (beq ? 3 : (lw ? 5 : 4)) + s.fw + ((lw || sw) ? s.mw : 0);
    e.rw  = (r || addi || lw) ? 1 : 0;
    e.m2r = lw ? 1 : 0;
    e.we  = sw ? s.mw + 1 : 0;
    e.io  = (lw || sw) ? s.mw + 1 : 0;
    e.pwc = beq ? 1 : 0;
    e.a10 = r ? 1 : 0;
    e.a01 = beq ? 1 : 0;
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input int fw, input int mw, input bit expect_done);
    stim_t s;
    exp_t e;
    s.op = op; s.fw = fw; s.mw = mw;
    sq.push_back(s);
    if (expect_done) begin
      e = model(s);
      eq.push_back(e);
      total_lat  += e.lat;
      total_done += 1;
    end
  endtask

  // Memory responder: supplies the opcode at each fetch and completes each
  // request after the queued number of wait cycles. Drops en while the last
  // queued instruction is in flight so the DUT parks in IDLE afterwards.
  initial begin
    stim_t cur;
    bit active;
    int cnt, w;
    active = 0; cnt = 0; w = 0;
    cur.op = OP_BEQ; cur.fw = 0; cur.mw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        mem_ready = 1'b0;
      end else begin
        if (active && mem_ready) active = 0;
        if (mem_req && !active) begin
          active = 1; cnt = 0;
          if (!iord) begin
            if (sq.size() > 0) begin
              cur = sq.pop_front();
              if (sq.size() == 0) en = 1'b0;
            end else begin
              check("unexpected_fetch", 1, 0);
              cur.op = OP_BEQ; cur.fw = 0; cur.mw = 0;
              en = 1'b0;
            end
            opcode = cur.op;
            w = cur.fw;
          end else begin
            w = cur.mw;
          end
        end
        if (active) begin
          mem_ready = (cnt == w);
          cnt++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));  // must be ignored
        end
      end
    end
  end

  // Monitor / scoreboard checker
  initial begin
    int cyc, rw, m2r, we, io, pwc, a10, a01, iw;
    exp_t e;
    cyc = 0; rw = 0; m2r = 0; we = 0; io = 0; pwc = 0; a10 = 0; a01 = 0; iw = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        in_i = 0;
      end else begin
        check("fetch_strobe_needs_ready",
              int'((ir_write || pc_write) && !(mem_req && mem_ready && !iord)), 0);
        if (!in_i && mem_req && !iord) begin
          in_i = 1;
          cyc = 0; rw = 0; m2r = 0; we = 0; io = 0; pwc = 0; a10 = 0; a01 = 0; iw = 0;
        end
        if (in_i) begin
          cyc++;
          rw  += int'(reg_write);
          m2r += int'(reg_write && mem_to_reg);
          we  += int'(mem_we);
          io  += int'(mem_req && iord);
          pwc += int'(pc_write_cond);
          a10 += int'(alu_op == 2'b10);
          a01 += int'(alu_op == 2'b01);
          iw  += int'(ir_write);
          if (instr_done) begin
            if (eq.size() == 0) begin
              check("unexpected_instr_done", 1, 0);
            end else begin
              e = eq.pop_front();
              check("latency", cyc, e.lat);
              check("reg_write_cycles", rw, e.rw);
              check("mem_to_reg_in_wb", m2r, e.m2r);
              check("mem_we_cycles", we, e.we);
              check("data_req_cycles", io, e.io);
              check("pc_write_cond_cycles", pwc, e.pwc);
              check("aluop_funct_cycles", a10, e.a10);
              check("aluop_sub_cycles", a01, e.a01);
              check("ir_write_cycles", iw, 1);
            end
            in_i = 0;
          end
        end else if (instr_done) begin
          check("stray_instr_done", 1, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_burst();
    int k;
    en = 1'b1;
    for (k = 0; k < 3000; k++) begin
      tick(1);
      if (eq.size() == 0 && sq.size() == 0 && !in_i) break;
    end
    check("drain_timeout", int'(k >= 3000), 0);
    tick(2);
    check("idle_after_burst", int'(outs), 0);
  endtask

  initial begin
    logic [6:0] ops [5];
    int k;
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ;
    rst = 1'b1; en = 1'b0; opcode = '0; mem_ready = 1'b0;

    // Reset state
    tick(2);
    check("reset_outputs", int'(outs), 0);
    check("reset_illegal", int'(illegal), 0);
    rst = 1'b0;
    tick(3);
    check("idle_no_en", int'(outs), 0);

`ifdef PERF_COUNTERS_EN
    // 17 back-to-back zero-wait BEQs: counters wrap at 16
    for (int i = 0; i < 17; i++) issue(OP_BEQ, 0, 0, 1);
    run_burst();
    check("instret_wrap", int'(instret_cnt), 1);
    check("cycle_wrap", int'(cycle_cnt), 3);
`endif

    // Directed cases
    issue(OP_R, 0, 0, 1);     run_burst();
    issue(OP_LW, 0, 3, 1);    run_burst();
    issue(OP_BEQ, 0, 0, 1);   run_burst();
    issue(OP_SW, 2, 1, 1);    run_burst();
    issue(OP_ADDI, 1, 0, 1);  run_burst();

    // Randomized bursts
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 12; i++)
        issue(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3), 1);
      run_burst();
    end

`ifdef PERF_COUNTERS_EN
    check("instret_total", int'(instret_cnt), total_done % (1 << CNT_W));
    check("cycle_total", int'(cycle_cnt), total_lat % (1 << CNT_W));
`endif

    // Reset while a fetch is still waiting on memory
    issue(OP_BEQ, 6, 0, 0);
    en = 1'b1;
    tick(3);
    check("pending_fetch_req", int'(mem_req), 1);
    rst = 1'b1;
    tick(1);
    check("abort_outputs", int'(outs), 0);
    rst = 1'b0;
    en = 1'b0;
    tick(2);
    check("abort_stays_idle", int'(outs), 0);

    // Illegal opcode traps and stays trapped
    issue(7'b1111111, 0, 0, 0);
    en = 1'b1;
    for (k = 0; k < 10; k++) begin
      tick(1);
      if (illegal) break;
    end
    check("trap_entry_time", k, 2);
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      tick(1);
      check("trap_illegal", int'(illegal), 1);
      check("trap_outputs", int'(outs), 0);
    end
    rst = 1'b1;
    en = 1'b0;
    tick(1);
    check("trap_reset_illegal", int'(illegal), 0);
    check("trap_reset_outputs", int'(outs), 0);
    rst = 1'b0;

    // Normal operation resumes after leaving TRAP
    issue(OP_LW, 1, 2, 1);
    run_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard timeout
  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
